// File: rtl/risc_program_loader.sv
// rtl/risc_program_loader.sv - byte-stream program loader and run controller for Single_Cycle_RISC (optional LOADER_CHECKSUM_EN)
module risc_program_loader #(
    parameter int unsigned RUN_TIMEOUT = 100000,
    parameter logic [7:0]  HDR_INSTR   = 8'hA5,
    parameter logic [7:0]  HDR_DATA    = 8'h5A,
    parameter logic [7:0]  HDR_RUN     = 8'hC3
) (
    input  logic        clk,
    input  logic        clr,
    input  logic        in_valid,
    input  logic [7:0]  in_byte,
    output logic        in_ready,
    output logic        test_normal,
    output logic        ext_instr_we,
    output logic [15:0] ext_instr_addr,
    output logic [15:0] ext_instr_data,
    output logic        ext_data_we,
    output logic [15:0] ext_data_addr,
    output logic [15:0] ext_data_data,
    input  logic        cpu_done,
    input  logic [15:0] cpu_outr,
    output logic [15:0] result,
    output logic        result_valid,
    output logic        busy,
    output logic [1:0]  err
);

    typedef enum logic [3:0] {
        S_IDLE,
        S_ADDR_H,
        S_ADDR_L,
        S_CNT_H,
        S_CNT_L,
        S_DAT_H,
        S_DAT_L,
        S_WRITE,
        S_CHK,
        S_RUN
    } state_t;

    // RUN index at which the timeout fires; only meaningful when the timeout is enabled
    localparam bit          TIMEOUT_EN   = (RUN_TIMEOUT != 0);
    localparam logic [31:0] TIMEOUT_LAST = RUN_TIMEOUT - 1;

    state_t      state;
    logic        to_data;     // current frame targets data memory
    logic [15:0] addr;
    logic [15:0] cnt;
    logic [7:0]  dat_hi;
    logic [31:0] run_cnt;
    logic        xfer;

`ifdef LOADER_CHECKSUM_EN
    logic [7:0]  chk;
`endif

    assign xfer = in_valid && in_ready;

    // Frame decoder, write strobes and run/halt controller
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state          <= S_IDLE;
            to_data        <= 1'b0;
            addr           <= 16'd0;
            cnt            <= 16'd0;
            dat_hi         <= 8'd0;
            run_cnt        <= 32'd0;
            in_ready       <= 1'b1;
            test_normal    <= 1'b0;
            ext_instr_we   <= 1'b0;
            ext_instr_addr <= 16'd0;
            ext_instr_data <= 16'd0;
            ext_data_we    <= 1'b0;
            ext_data_addr  <= 16'd0;
            ext_data_data  <= 16'd0;
            result         <= 16'd0;
            result_valid   <= 1'b0;
            busy           <= 1'b0;
            err            <= 2'd0;
`ifdef LOADER_CHECKSUM_EN
            chk            <= 8'd0;
`endif
        end else begin
            // strobes are single-cycle; only the DAT_L accept raises one
            ext_instr_we <= 1'b0;
            ext_data_we  <= 1'b0;

            case (state)
                S_IDLE: begin
                    if (xfer) begin
                        if (in_byte == HDR_INSTR || in_byte == HDR_DATA) begin
                            to_data      <= (in_byte == HDR_DATA);
                            err          <= 2'd0;
                            result_valid <= 1'b0;
                            busy         <= 1'b1;
                            state        <= S_ADDR_H;
                        end else if (in_byte == HDR_RUN) begin
                            err          <= 2'd0;
                            result_valid <= 1'b0;
                            busy         <= 1'b1;
                            in_ready     <= 1'b0;
                            test_normal  <= 1'b1;
                            run_cnt      <= 32'd0;
                            state        <= S_RUN;
                        end else begin
                            err <= 2'd1;
                        end
                    end
                end
                S_ADDR_H: begin
                    if (xfer) begin
                        addr[15:8] <= in_byte;
                        state      <= S_ADDR_L;
                    end
                end
                S_ADDR_L: begin
                    if (xfer) begin
                        addr[7:0] <= in_byte;
                        state     <= S_CNT_H;
                    end
                end
                S_CNT_H: begin
                    if (xfer) begin
                        cnt[15:8] <= in_byte;
                        state     <= S_CNT_L;
                    end
                end
                S_CNT_L: begin
                    if (xfer) begin
                        cnt[7:0] <= in_byte;
                        if ({cnt[15:8], in_byte} == 16'd0) begin
`ifdef LOADER_CHECKSUM_EN
                            state <= S_CHK;
`else
                            state <= S_IDLE;
                            busy  <= 1'b0;
`endif
                        end else begin
                            state <= S_DAT_H;
                        end
                    end
                end
                S_DAT_H: begin
                    if (xfer) begin
                        dat_hi <= in_byte;
                        state  <= S_DAT_L;
                    end
                end
                S_DAT_L: begin
                    if (xfer) begin
                        if (to_data) begin
                            ext_data_we   <= 1'b1;
                            ext_data_addr <= addr;
                            ext_data_data <= {dat_hi, in_byte};
                        end else begin
                            ext_instr_we   <= 1'b1;
                            ext_instr_addr <= addr;
                            ext_instr_data <= {dat_hi, in_byte};
                        end
                        in_ready <= 1'b0;
                        state    <= S_WRITE;
                    end
                end
                S_WRITE: begin
                    addr     <= addr + 16'd1;
                    cnt      <= cnt - 16'd1;
                    in_ready <= 1'b1;
                    if (cnt == 16'd1) begin
`ifdef LOADER_CHECKSUM_EN
                        state <= S_CHK;
`else
                        state <= S_IDLE;
                        busy  <= 1'b0;
`endif
                    end else begin
                        state <= S_DAT_H;
                    end
                end
`ifdef LOADER_CHECKSUM_EN
                S_CHK: begin
                    if (xfer) begin
                        if ((chk ^ in_byte) != 8'h00) begin
                            err <= 2'd3;
                        end
                        busy  <= 1'b0;
                        state <= S_IDLE;
                    end
                end
`endif
                S_RUN: begin
                    if (run_cnt != 32'hFFFF_FFFF) begin
                        run_cnt <= run_cnt + 32'd1;
                    end
                    // halt is checked before timeout so it wins a tie
                    if (run_cnt >= 32'd2 && !cpu_done) begin
                        result       <= cpu_outr;
                        result_valid <= 1'b1;
                        test_normal  <= 1'b0;
                        in_ready     <= 1'b1;
                        busy         <= 1'b0;
                        state        <= S_IDLE;
                    end else if (TIMEOUT_EN && run_cnt == TIMEOUT_LAST) begin
                        err         <= 2'd2;
                        test_normal <= 1'b0;
                        in_ready    <= 1'b1;
                        busy        <= 1'b0;
                        state       <= S_IDLE;
                    end
                end
                default: begin
                    in_ready    <= 1'b1;
                    test_normal <= 1'b0;
                    busy        <= 1'b0;
                    state       <= S_IDLE;
                end
            endcase

`ifdef LOADER_CHECKSUM_EN
            // running XOR over the frame, restarted by the header byte
            if (xfer) begin
                chk <= (state == S_IDLE) ? in_byte : (chk ^ in_byte);
            end
`endif
        end
    end

endmodule

// File: tb/tb_risc_program_loader.sv
// tb/tb_risc_program_loader.sv - table-driven bench for risc_program_loader
module tb_risc_program_loader;

    logic        clk;
    logic        clr;
    logic        in_valid;
    logic [7:0]  in_byte;
    logic        in_ready;
    logic        test_normal;
    logic        ext_instr_we;
    logic [15:0] ext_instr_addr;
    logic [15:0] ext_instr_data;
    logic        ext_data_we;
    logic [15:0] ext_data_addr;
    logic [15:0] ext_data_data;
    logic        cpu_done;
    logic [15:0] cpu_outr;
    logic [15:0] result;
    logic        result_valid;
    logic        busy;
    logic [1:0]  err;

    int vectors = 0;
    int errors  = 0;

    // CPU model: 0 = drop done after 20 run cycles, 1 = never halt, 2 = done low always
    int          cpu_mode;
    int          tn_cnt;

    risc_program_loader #(.RUN_TIMEOUT(50)) dut (
        .clk            (clk),
        .clr            (clr),
        .in_valid       (in_valid),
        .in_byte        (in_byte),
        .in_ready       (in_ready),
        .test_normal    (test_normal),
        .ext_instr_we   (ext_instr_we),
        .ext_instr_addr (ext_instr_addr),
        .ext_instr_data (ext_instr_data),
        .ext_data_we    (ext_data_we),
        .ext_data_addr  (ext_data_addr),
        .ext_data_data  (ext_data_data),
        .cpu_done       (cpu_done),
        .cpu_outr       (cpu_outr),
        .result         (result),
        .result_valid   (result_valid),
        .busy           (busy),
        .err            (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        tn_cnt <= test_normal ? tn_cnt + 1 : 0;
    end

    always_comb begin
        cpu_done = 1'b1;
        if (cpu_mode == 0) cpu_done = (tn_cnt < 20);
        else if (cpu_mode == 2) cpu_done = 1'b0;
    end

    typedef struct {
        logic [7:0]  b;
        logic        we_i;
        logic        we_d;
        logic [15:0] addr;
        logic [15:0] data;
        logic        busy;
        logic [1:0]  err;
    } vec_t;

    vec_t vecs[$];
    int   t1_last;

    function automatic void add(input logic [7:0] b, input logic we_i, input logic we_d,
                                input logic [15:0] a, input logic [15:0] d,
                                input logic bz, input logic [1:0] e);
        vec_t v;
        v.b = b; v.we_i = we_i; v.we_d = we_d; v.addr = a; v.data = d; v.busy = bz; v.err = e;
        vecs.push_back(v);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        int n;
        n = 0;
        @(negedge clk);
        in_valid = 1'b1;
        in_byte  = b;
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            vectors++;
            errors++;
            $display("FAIL send_timeout: in_ready stuck at 0, expected 1 within 100 cycles");
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic apply_range(input int lo, input int hi);
        for (int i = lo; i <= hi; i++) begin
            send_byte(vecs[i].b);
            check($sformatf("v%0d instr_we", i), ext_instr_we, vecs[i].we_i);
            check($sformatf("v%0d data_we", i), ext_data_we, vecs[i].we_d);
            check($sformatf("v%0d busy", i), busy, vecs[i].busy);
            check($sformatf("v%0d err", i), err, vecs[i].err);
            if (vecs[i].we_i) begin
                check($sformatf("v%0d instr_addr", i), ext_instr_addr, vecs[i].addr);
                check($sformatf("v%0d instr_data", i), ext_instr_data, vecs[i].data);
            end
            if (vecs[i].we_d) begin
                check($sformatf("v%0d data_addr", i), ext_data_addr, vecs[i].addr);
                check($sformatf("v%0d data_data", i), ext_data_data, vecs[i].data);
            end
            if (vecs[i].we_i || vecs[i].we_d) begin
                @(posedge clk);
                #1;
                check($sformatf("v%0d instr_we_pulse", i), ext_instr_we, 1'b0);
                check($sformatf("v%0d data_we_pulse", i), ext_data_we, 1'b0);
            end
        end
    endtask

    task automatic count_run(output int n);
        n = 0;
        while (test_normal && n < 200) begin
            n++;
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, " in_ready"}, in_ready, 1'b1);
        check({tag, " busy"}, busy, 1'b0);
        check({tag, " test_normal"}, test_normal, 1'b0);
        check({tag, " err"}, err, 2'd0);
        check({tag, " result_valid"}, result_valid, 1'b0);
        check({tag, " result"}, result, 16'h0000);
        check({tag, " instr_we"}, ext_instr_we, 1'b0);
        check({tag, " data_we"}, ext_data_we, 1'b0);
        check({tag, " instr_addr"}, ext_instr_addr, 16'h0000);
        check({tag, " instr_data"}, ext_instr_data, 16'h0000);
        check({tag, " data_addr"}, ext_data_addr, 16'h0000);
        check({tag, " data_data"}, ext_data_data, 16'h0000);
    endtask

    initial begin
        int n;

        // T1: instruction frame, two words at 0010
        add(8'hA5, 0, 0, 16'h0000, 16'h0000, 1, 0);
        add(8'h00, 0, 0, 16'h0000, 16'h0000, 1, 0);
        add(8'h10, 0, 0, 16'h0000, 16'h0000, 1, 0);
        add(8'h00, 0, 0, 16'h0000, 16'h0000, 1, 0);
        add(8'h02, 0, 0, 16'h0000, 16'h0000, 1, 0);
        add(8'h12, 0, 0, 16'h0000, 16'h0000, 1, 0);
        add(8'h34, 1, 0, 16'h0010, 16'h1234, 1, 0);
        add(8'hAB, 0, 0, 16'h0000, 16'h0000, 1, 0);
        add(8'hCD, 1, 0, 16'h0011, 16'hABCD, 1, 0);
`ifdef LOADER_CHECKSUM_EN
        add(8'hF7, 0, 0, 16'h0000, 16'h0000, 0, 0);
`endif
        t1_last = vecs.size() - 1;
        // T2: data frame wrapping FFFF -> 0000
        add(8'h5A, 0, 0, 16'h0000, 16'h0000, 1, 0);
        add(8'hFF, 0, 0, 16'h0000, 16'h0000, 1, 0);
        add(8'hFF, 0, 0, 16'h0000, 16'h0000, 1, 0);
        add(8'h00, 0, 0, 16'h0000, 16'h0000, 1, 0);
        add(8'h02, 0, 0, 16'h0000, 16'h0000, 1, 0);
        add(8'h00, 0, 0, 16'h0000, 16'h0000, 1, 0);
        add(8'h01, 0, 1, 16'hFFFF, 16'h0001, 1, 0);
        add(8'h00, 0, 0, 16'h0000, 16'h0000, 1, 0);
        add(8'h02, 0, 1, 16'h0000, 16'h0002, 1, 0);
`ifdef LOADER_CHECKSUM_EN
        add(8'h5B, 0, 0, 16'h0000, 16'h0000, 0, 0);
`endif
        // T5: bad header, sticky err, then an empty frame
        add(8'h77, 0, 0, 16'h0000, 16'h0000, 0, 1);
        add(8'h12, 0, 0, 16'h0000, 16'h0000, 0, 1);
        add(8'hA5, 0, 0, 16'h0000, 16'h0000, 1, 0);
        add(8'h00, 0, 0, 16'h0000, 16'h0000, 1, 0);
        add(8'h00, 0, 0, 16'h0000, 16'h0000, 1, 0);
        add(8'h00, 0, 0, 16'h0000, 16'h0000, 1, 0);
`ifdef LOADER_CHECKSUM_EN
        add(8'h00, 0, 0, 16'h0000, 16'h0000, 1, 0);
        add(8'hA5, 0, 0, 16'h0000, 16'h0000, 0, 0);
        add(8'hA5, 0, 0, 16'h0000, 16'h0000, 1, 0);
        add(8'h00, 0, 0, 16'h0000, 16'h0000, 1, 0);
        add(8'h00, 0, 0, 16'h0000, 16'h0000, 1, 0);
        add(8'h00, 0, 0, 16'h0000, 16'h0000, 1, 0);
        add(8'h00, 0, 0, 16'h0000, 16'h0000, 1, 0);
        add(8'h00, 0, 0, 16'h0000, 16'h0000, 0, 3);
`else
        add(8'h00, 0, 0, 16'h0000, 16'h0000, 0, 0);
`endif

        clr      = 1'b0;
        in_valid = 1'b0;
        in_byte  = 8'h00;
        cpu_mode = 0;
        cpu_outr = 16'h0042;
        repeat (3) @(posedge clk);
        #1;
        check_reset_values("reset");
        @(negedge clk);
        clr = 1'b1;
        @(posedge clk);
        #1;
        check_reset_values("post_reset");

        apply_range(0, vecs.size() - 1);

        // idle hold of the last written addr/data
        repeat (3) @(posedge clk);
        #1;
        check("idle busy", busy, 1'b0);
        check("hold instr_addr", ext_instr_addr, 16'h0011);
        check("hold instr_data", ext_instr_data, 16'hABCD);
        check("hold data_addr", ext_data_addr, 16'h0000);
        check("hold data_data", ext_data_data, 16'h0002);

        // T3: halt after 20 cycles
        cpu_mode = 0;
        cpu_outr = 16'h0042;
        send_byte(8'hC3);
        check("t3 in_ready", in_ready, 1'b0);
        count_run(n);
        check("t3 run_cycles", n, 21);
        check("t3 result", result, 16'h0042);
        check("t3 result_valid", result_valid, 1'b1);
        check("t3 err", err, 2'd0);
        check("t3 busy", busy, 1'b0);

        // halt ignored for the first two run cycles
        cpu_mode = 2;
        cpu_outr = 16'h0077;
        send_byte(8'hC3);
        count_run(n);
        check("early run_cycles", n, 3);
        check("early result", result, 16'h0077);
        check("early result_valid", result_valid, 1'b1);

        // T4: timeout with done held high
        cpu_mode = 1;
        cpu_outr = 16'h9999;
        send_byte(8'hC3);
        count_run(n);
        check("t4 run_cycles", n, 50);
        check("t4 err", err, 2'd2);
        check("t4 result_valid", result_valid, 1'b0);
        check("t4 result", result, 16'h0077);
        repeat (5) @(posedge clk);
        #1;
        check("t4 err_sticky", err, 2'd2);
        check("t4 in_ready", in_ready, 1'b1);
        cpu_mode = 0;

        // T6: reset while DAT_L byte is presented
        for (int i = 0; i <= 5; i++) send_byte(vecs[i].b);
        @(negedge clk);
        in_valid = 1'b1;
        in_byte  = 8'h34;
        clr      = 1'b0;
        @(posedge clk);
        #1;
        check_reset_values("t6_abort");
        @(negedge clk);
        in_valid = 1'b0;
        clr      = 1'b1;
        apply_range(0, t1_last);
        repeat (3) @(posedge clk);
        #1;
        check("t6 busy", busy, 1'b0);
        check("t6 data_we", ext_data_we, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
